// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, default widths and the test-pattern function
// for the RAM BIST sequencer.
`default_nettype none

package ram_bist_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // Wide on purpose: callers truncate to their own data width, which gives the
    // mod 2^DATA_WIDTH wrap for free.
    function automatic logic [63:0] pattern_exp(input logic [63:0] seed_v,
                                                input logic [63:0] addr_v);
        return seed_v + addr_v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: writes a seed+address pattern to every RAM word, reads it back
// over the async read path and reports pass, mismatch count and first failing address.
`default_nettype none

module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);

    bist_state_t           state;
    bist_state_t           state_nx;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] exp_val;
    logic                  last;
    logic                  mismatch;
    logic [ADDR_WIDTH:0]   err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // RAM controls are decoded from registered state only, so an async reset
    // forces them to zero immediately.
    always_comb begin
        state_nx = state;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        mismatch = 1'b0;
        exp_val  = DATA_WIDTH'(pattern_exp(64'(seed_q), 64'(cnt)));
        last     = (cnt == LAST_ADDR);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt;
                ram_din  = exp_val;
                if (last) begin
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                ram_addr = cnt;
                mismatch = (ram_dout != exp_val);
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase

        err_nx = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX)) begin
            err_nx = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            seed_q    <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_q    <= seed;
                        cnt       <= '0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        pass      <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                ST_READ: begin
                    cnt     <= last ? '0 : cnt + 1'b1;
                    err_cnt <= err_nx;
                    if (mismatch && (err_cnt == '0)) begin
                        fail_addr <= cnt;
                    end
                    // Uses err_nx so the final location's compare is in the verdict.
                    if (last) begin
                        pass <= (err_nx == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: RAM model with fault injection, table vectors, random seeds/faults
// checked against a pattern model, plus start-ignore and mid-test reset sequences.
`default_nettype none

module tb_ram_bist_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] fail_addr;

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed     (seed),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model: mode 0 = true readback with optional bit-0 flips, mode 1 = reads 0.
    logic [DW-1:0] mem [DEPTH];
    int            wr_count = 0;
    logic          clr = 1'b0;
    int            fault_mode = 0;
    logic [DEPTH-1:0] flip_mask = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hEE;
            wr_count <= 0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr_count      <= wr_count + 1;
        end
    end

    always_comb begin
        if (fault_mode == 1) ram_dout = '0;
        else ram_dout = mem[ram_addr] ^ {{(DW-1){1'b0}}, flip_mask[ram_addr]};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference: what the test should report, from the stored pattern and fault setup.
    task automatic model(input logic [DW-1:0] s, input int mode, input logic [DEPTH-1:0] mask,
                         output int e_err, output int e_fail, output int e_pass);
        int n = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            int stored = (s + a) % 256;
            int rd = (mode == 1) ? 0 : (stored ^ int'(mask[a]));
            if (rd != stored) begin
                n++;
                if (first < 0) first = a;
            end
        end
        e_err  = (n > DEPTH) ? DEPTH : n;
        e_fail = (first < 0) ? 0 : first;
        e_pass = (n == 0) ? 1 : 0;
    endtask

    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic check_mem(input logic [DW-1:0] s, input string tag);
        chk({tag, "_wr_count"}, wr_count, DEPTH);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("%s_mem%0d", tag, a), int'(mem[a]), (s + a) % 256);
    endtask

    task automatic run_test(input logic [DW-1:0] s, input int mode, input logic [DEPTH-1:0] mask,
                            input int e_err, input int e_fail, input int e_pass, input string tag);
        int n;
        clear_mem();
        fault_mode = mode;
        flip_mask  = mask;
        @(negedge clk) begin start = 1'b1; seed = s; end
        @(negedge clk) begin start = 1'b0; seed = ~s; end
        n = 0;
        chk({tag, "_busy"}, int'(busy), 1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 2 * DEPTH);
        chk({tag, "_pass"}, int'(pass), e_pass);
        chk({tag, "_err_cnt"}, int'(err_cnt), e_err);
        chk({tag, "_fail_addr"}, int'(fail_addr), e_fail);
        check_mem(s, tag);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, int'(done), 0);
        chk({tag, "_pass_held"}, int'(pass), e_pass);
        fault_mode = 0;
        flip_mask  = '0;
    endtask

    typedef struct {
        logic [DW-1:0]    seed;
        int               mode;
        logic [DEPTH-1:0] mask;
        int               err;
        int               fail;
        int               pass;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'h10, 0, 8'h00, 0, 0, 1};
        vecs[1] = '{8'hFC, 0, 8'h00, 0, 0, 1};
        vecs[2] = '{8'h10, 0, 8'b0010_0100, 2, 2, 0};
        vecs[3] = '{8'h01, 1, 8'h00, 8, 0, 0};

        #12;
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_fail", int'(fail_addr), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_test(vecs[i].seed, vecs[i].mode, vecs[i].mask,
                     vecs[i].err, vecs[i].fail, vecs[i].pass, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0]    s;
            logic [DEPTH-1:0] m;
            int md, ee, ef, ep;
            s  = DW'($urandom);
            md = ($urandom_range(0, 5) == 0) ? 1 : 0;
            m  = ($urandom_range(0, 2) == 0) ? '0 : DEPTH'($urandom);
            model(s, md, m, ee, ef, ep);
            run_test(s, md, m, ee, ef, ep, $sformatf("rnd%0d", i));
        end

        // start pulses mid-run and in DONE must be ignored
        begin
            int n;
            int dones = 0;
            int busy_after = 0;
            int done_at = -1;
            clear_mem();
            @(negedge clk) begin start = 1'b1; seed = 8'h33; end
            @(negedge clk) begin start = 1'b0; seed = 8'hAA; end
            for (n = 0; n < 30; n++) begin
                if (done) begin
                    dones++;
                    done_at = n;
                    chk("ign_pass", int'(pass), 1);
                end else if (done_at >= 0 && busy) begin
                    busy_after++;
                end
                start = (n == 3 || n == 15 || done);
                @(negedge clk);
                start = 1'b0;
            end
            chk("ign_done_pulses", dones, 1);
            chk("ign_done_at", done_at, 2 * DEPTH);
            chk("ign_no_restart", busy_after, 0);
            check_mem(8'h33, "ign");
        end

        // async reset in READ at cnt=4, then a clean rerun
        begin
            int n = 0;
            clear_mem();
            @(negedge clk) begin start = 1'b1; seed = 8'h40; end
            @(negedge clk) start = 1'b0;
            while (n < 2 * DEPTH - 4) begin
                @(negedge clk);
                n++;
            end
            chk("abort_pre_addr", int'(ram_addr), 4);
            chk("abort_pre_we", int'(ram_we), 0);
            chk("abort_pre_busy", int'(busy), 1);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_addr", int'(ram_addr), 0);
            chk("abort_we", int'(ram_we), 0);
            chk("abort_din", int'(ram_din), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_pass", int'(pass), 0);
            chk("abort_err", int'(err_cnt), 0);
            chk("abort_fail", int'(fail_addr), 0);
            @(negedge clk) rst_n = 1'b1;
            run_test(8'h5A, 0, '0, 0, 0, 1, "after_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
